// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the single-issue RV32I pipeline.
//
// Owns the fetch PC, issues one word request at a time to instruction
// memory over a valid/ready handshake, and presents each returned
// instruction with its PC in the IF/ID register. A one-entry skid buffer
// absorbs a response that arrives while decode is stalled. Redirects from
// execute flush IF/ID and the skid buffer, and squash an in-flight fetch.
//
// Parameters
//   D_WIDTH   instruction / address width
//   RESET_PC  first fetch address after reset (bits [1:0] must be 0)
//
// Ports
//   clk, rst_n                 clock, async active-low reset (sync release)
//   imem_req_valid/ready       request handshake; imem_addr is word aligned
//   imem_rsp_valid/data        in-order response, >= 1 cycle after accept
//   redirect_valid/pc          taken branch / JAL / JALR target from execute
//   stall_d                    decode cannot accept; hold IF/ID
//   valid_d, instr_d, pc_d     IF/ID register (instr_d[31:7] feeds signExtend)
//   pcplus4_d                  pc_d + 4, wrapping
module fetch_unit #(
    parameter int                 D_WIDTH  = 32,
    parameter logic [D_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [D_WIDTH-1:0] imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [D_WIDTH-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [D_WIDTH-1:0] redirect_pc,
    input  logic               stall_d,
    output logic               valid_d,
    output logic [D_WIDTH-1:0] instr_d,
    output logic [D_WIDTH-1:0] pc_d,
    output logic [D_WIDTH-1:0] pcplus4_d
);

    localparam logic [D_WIDTH-1:0] WORD = D_WIDTH'(4);

    // S_REQ : ready to issue the next request
    // S_WAIT: request outstanding, its response will be delivered
    // S_DROP: request outstanding, its response belongs to a squashed path
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             state;
    logic [D_WIDTH-1:0] pc_f;
    logic [D_WIDTH-1:0] req_pc;
    logic               skid_valid;
    logic [D_WIDTH-1:0] skid_instr;
    logic [D_WIDTH-1:0] skid_pc;

    logic               handshake;
    logic               deliver;
    logic [D_WIDTH-1:0] redirect_target;

    // Request valid depends on registers only, so there is no combinational
    // path from memory ready or the redirect back to the request. Holding
    // off while the skid buffer is full caps storage at two instructions.
    assign imem_req_valid  = (state == S_REQ) && !skid_valid;
    assign imem_addr       = pc_f;
    assign handshake       = imem_req_valid && imem_req_ready;
    // A response arriving in the redirect cycle is from the old path.
    assign deliver         = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign redirect_target = {redirect_pc[D_WIDTH-1:2], 2'b00};
    assign pcplus4_d       = pc_d + WORD;

    // Fetch control: state, fetch PC and in-flight request PC.
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_REQ;
            pc_f   <= RESET_PC;
            req_pc <= '0;
        end else begin
            if (handshake) begin
                req_pc <= pc_f;
                pc_f   <= pc_f + WORD;
            end
            // Later assignment wins: a redirect overrides the increment.
            if (redirect_valid) begin
                pc_f <= redirect_target;
            end

            case (state)
                S_REQ: begin
                    // A request accepted alongside a redirect is old-path.
                    if (handshake) begin
                        state <= redirect_valid ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= S_REQ;
                    end else if (redirect_valid) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Skid buffer and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data fields are reset as well (not only the valid
            // bits) so decode and signExtend see defined values from reset.
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            valid_d    <= 1'b0;
            instr_d    <= '0;
            pc_d       <= '0;
        end else if (redirect_valid) begin
            // Flush wins over stall: nothing fetched so far is on the new path.
            valid_d    <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!stall_d) begin
            if (skid_valid) begin
                // The skid entry is older than anything in flight.
                valid_d    <= 1'b1;
                instr_d    <= skid_instr;
                pc_d       <= skid_pc;
                skid_valid <= 1'b0;
            end else if (deliver) begin
                valid_d <= 1'b1;
                instr_d <= imem_rsp_data;
                pc_d    <= req_pc;
            end else begin
                valid_d <= 1'b0;
            end
        end else if (deliver) begin
            // Stalled: an empty IF/ID may still fill; a live one is held and
            // the new instruction parks in the skid buffer.
            if (!valid_d) begin
                valid_d <= 1'b1;
                instr_d <= imem_rsp_data;
                pc_d    <= req_pc;
            end else begin
                skid_valid <= 1'b1;
                skid_instr <= imem_rsp_data;
                skid_pc    <= req_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// A memory model answers each accepted request with addr ^ 32'hA5A5_0000
// after a chosen latency. A program-order model tracks the next PC decode
// should consume and the next address fetch should request; it restarts
// both at the redirect target. Directed vectors, hand sequences for the
// multi-cycle corners, and a randomized run are all checked against it.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;

    // Second instance exercising the top-of-address-space reset PC.
    logic        rv2;
    logic        ready2;
    logic [31:0] addr2;
    logic        rsp_valid2;
    logic [31:0] rsp_data2;
    logic        vd2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic [31:0] pcp4_2;

    always #5 clk = ~clk;

    fetch_unit #(.D_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_d        (stall_d),
        .valid_d        (valid_d),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pcplus4_d      (pcplus4_d)
    );

    fetch_unit #(.D_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (rv2),
        .imem_req_ready (ready2),
        .imem_addr      (addr2),
        .imem_rsp_valid (rsp_valid2),
        .imem_rsp_data  (rsp_data2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .stall_d        (1'b0),
        .valid_d        (vd2),
        .instr_d        (instr2),
        .pc_d           (pc2),
        .pcplus4_d      (pcp4_2)
    );

    int n_checks   = 0;
    int n_pass     = 0;
    int n_consumed = 0;

    // Program-order model
    bit          model_on;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;

    // Memory model: one outstanding request, fixed or random latency
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat;
    bit          rand_lat;

    typedef struct {
        bit          stall;
        bit          rv;
        logic [31:0] addr;
        bit          vd;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One clock cycle. Inputs for this cycle are already applied; DUT
    // request outputs depend only on registers, so they are stable here.
    task automatic tick();
        logic        hs;
        logic        rsp;
        logic [31:0] a;
        bit          hold_chk;
        hs       = imem_req_valid && imem_req_ready;
        a        = imem_addr;
        rsp      = imem_rsp_valid;
        hold_chk = 1'b0;
        if (model_on) begin
            if (valid_d && !stall_d) begin
                check("consume_pc", pc_d, exp_pc);
                check("consume_instr", instr_d, exp_pc ^ K);
                check("consume_pcplus4", pcplus4_d, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (hs) begin
                check("req_addr", a, exp_req);
                check("one_outstanding", {31'd0, mem_busy}, 32'd0);
                exp_req = exp_req + 32'd4;
            end
            if (redirect_valid) begin
                exp_pc  = redirect_pc & 32'hFFFF_FFFC;
                exp_req = redirect_pc & 32'hFFFF_FFFC;
            end
            hold_chk = imem_req_valid && !imem_req_ready && !redirect_valid;
        end
        @(posedge clk);
        #1;
        if (rsp) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (hs) begin
            mem_busy = 1'b1;
            mem_addr = a;
            mem_cnt  = (rand_lat ? int'($urandom_range(3, 1)) : lat) - 1;
        end
        if (hold_chk) begin
            check("req_held_valid", {31'd0, imem_req_valid}, 32'd1);
            check("req_held_addr", imem_addr, a);
        end
        @(negedge clk);
        imem_rsp_valid = mem_busy && (mem_cnt == 0);
        imem_rsp_data  = mem_addr ^ K;
    endtask

    // Reset both instances and the memory model; ends at the negedge that
    // begins cycle 0.
    task automatic do_reset();
        rst_n          = 1'b0;
        model_on       = 1'b0;
        mem_busy       = 1'b0;
        mem_cnt        = 0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall_d        = 1'b0;
        ready2         = 1'b0;
        rsp_valid2     = 1'b0;
        rsp_data2      = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid_d", {31'd0, valid_d}, 32'd0);
        check("rst_pc_d", pc_d, 32'h0);
        check("rst_instr_d", instr_d, 32'h0);
        check("rst_pcplus4", pcplus4_d, 32'd4);
        check("rst2_addr", addr2, 32'hFFFF_FFFC);
        rst_n    = 1'b1;
        exp_pc   = 32'h0;
        exp_req  = 32'h0;
        model_on = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Basic flow at L=1, then a 5-cycle stall that fills the skid buffer.
        //            stall rv  addr          vd  pc
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[4]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[6]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
        vecs[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        vecs[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        vecs[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        vecs[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        vecs[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
        vecs[12] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
        vecs[13] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[14] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10};

        lat      = 1;
        rand_lat = 1'b0;

        // ---- table-driven vectors ----
        do_reset();
        imem_req_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            stall_d = vecs[i].stall;
            check($sformatf("vec%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].rv});
            if (vecs[i].rv) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("vec%0d_valid_d", i), {31'd0, valid_d}, {31'd0, vecs[i].vd});
            if (vecs[i].vd) begin
                check($sformatf("vec%0d_pc_d", i), pc_d, vecs[i].pc);
                check($sformatf("vec%0d_instr_d", i), instr_d, vecs[i].pc ^ K);
            end
            tick();
        end
        stall_d = 1'b0;

        // ---- redirect to 0x103 while WAIT, L=3 ----
        do_reset();
        lat = 3;
        imem_req_ready = 1'b1;
        repeat (4) tick();                       // c0..c3
        check("w_vd_c4", {31'd0, valid_d}, 32'd1);
        check("w_pc_c4", pc_d, 32'h0);
        stall_d = 1'b1;
        tick();                                  // c4: request 0x4 accepted
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        check("w_vd_c5", {31'd0, valid_d}, 32'd1);
        tick();                                  // c5: redirect in WAIT
        redirect_valid = 1'b0;
        stall_d        = 1'b0;
        check("w_vd_c6", {31'd0, valid_d}, 32'd0);
        check("w_rv_c6", {31'd0, imem_req_valid}, 32'd0);
        tick();
        check("w_rv_c7", {31'd0, imem_req_valid}, 32'd0);
        tick();                                  // c7: squashed response
        check("w_vd_c8", {31'd0, valid_d}, 32'd0);
        check("w_rv_c8", {31'd0, imem_req_valid}, 32'd1);
        check("w_addr_c8", imem_addr, 32'h100);
        repeat (4) tick();                       // c8..c11
        check("w_vd_c12", {31'd0, valid_d}, 32'd1);
        check("w_pc_c12", pc_d, 32'h100);
        check("w_instr_c12", instr_d, 32'h100 ^ K);

        // ---- redirect with a response, then with a handshake, L=1 ----
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        tick();                                  // c0: request 0x0
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();                                  // c1: response + redirect
        redirect_pc = 32'h0000_0302;
        check("h_vd_c2", {31'd0, valid_d}, 32'd0);
        check("h_rv_c2", {31'd0, imem_req_valid}, 32'd1);
        check("h_addr_c2", imem_addr, 32'h200);
        tick();                                  // c2: handshake + redirect
        redirect_valid = 1'b0;
        check("h_rv_c3", {31'd0, imem_req_valid}, 32'd0);
        tick();                                  // c3: response dropped
        check("h_vd_c4", {31'd0, valid_d}, 32'd0);
        check("h_addr_c4", imem_addr, 32'h300);
        check("h_rv_c4", {31'd0, imem_req_valid}, 32'd1);
        repeat (2) tick();
        check("h_vd_c6", {31'd0, valid_d}, 32'd1);
        check("h_pc_c6", pc_d, 32'h300);

        // ---- redirect while stalled with the skid buffer full ----
        do_reset();
        imem_req_ready = 1'b1;
        repeat (2) tick();
        check("s_pc_c2", pc_d, 32'h0);
        stall_d = 1'b1;
        repeat (2) tick();                       // c2 request, c3 response to skid
        check("s_rv_c4", {31'd0, imem_req_valid}, 32'd0);
        check("s_vd_c4", {31'd0, valid_d}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        stall_d        = 1'b0;
        check("s_vd_c5", {31'd0, valid_d}, 32'd0);
        check("s_rv_c5", {31'd0, imem_req_valid}, 32'd1);
        check("s_addr_c5", imem_addr, 32'h400);
        repeat (2) tick();
        check("s_vd_c7", {31'd0, valid_d}, 32'd1);
        check("s_pc_c7", pc_d, 32'h400);

        // ---- memory not ready for 4 cycles ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("nr_rv", {31'd0, imem_req_valid}, 32'd1);
            check("nr_addr", imem_addr, 32'h0);
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        check("nr_rv_after", {31'd0, imem_req_valid}, 32'd0);

        // ---- RESET_PC = 0xFFFF_FFFC wraps ----
        do_reset();
        check("wrap_rv_c0", {31'd0, rv2}, 32'd1);
        check("wrap_addr_c0", addr2, 32'hFFFF_FFFC);
        ready2 = 1'b1;
        tick();
        ready2     = 1'b0;
        rsp_valid2 = 1'b1;
        rsp_data2  = 32'hFFFF_FFFC ^ K;
        check("wrap_rv_c1", {31'd0, rv2}, 32'd0);
        tick();
        rsp_valid2 = 1'b0;
        check("wrap_vd", {31'd0, vd2}, 32'd1);
        check("wrap_pc", pc2, 32'hFFFF_FFFC);
        check("wrap_instr", instr2, 32'hFFFF_FFFC ^ K);
        check("wrap_pcplus4", pcp4_2, 32'h0);
        check("wrap_addr_c2", addr2, 32'h0);

        // ---- randomized run against the program-order model ----
        do_reset();
        rand_lat   = 1'b1;
        n_consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            stall_d        = ($urandom_range(9, 0) < 3);
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        check("random_progress", {31'd0, n_consumed >= 100}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
